// File: rtl/tick_sequencer.sv
// Software-controlled prescaler: one-cycle tick every div_reg+1 sysclk cycles,
// counted up to a programmable target, with IDLE/RUN/PAUSE/DONE run control.
module tick_sequencer #(
    parameter int unsigned   W       = 8,
    parameter int unsigned   CW      = 8,
    parameter logic [W-1:0]  DIV_RST = 8'hFF
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          start,
    input  logic          pause,
    input  logic          stop,
    input  logic          div_load,
    input  logic [W-1:0]  div_val,
    input  logic          tgt_load,
    input  logic [CW-1:0] tgt_val,
    output logic          tick,
    output logic [CW-1:0] tick_count,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_presc;
    logic [W-1:0]  r_div;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_tgt;
    logic          r_tick;
    logic          r_cfg_err;

    logic          w_cfg_ok;
    logic          w_period_end;
    logic [CW-1:0] w_count_inc;
    logic          w_hit_tgt;

    assign w_cfg_ok     = (r_state == StIdle) || (r_state == StDone);
    assign w_period_end = (r_presc == r_div);
    assign w_count_inc  = r_count + CW'(1);
    assign w_hit_tgt    = (r_tgt != '0) && (w_count_inc == r_tgt);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_presc   <= '0;
            r_div     <= DIV_RST;
            r_count   <= '0;
            r_tgt     <= '0;
            r_tick    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_tick    <= 1'b0;
            r_cfg_err <= 1'b0;

            if (div_load || tgt_load) begin
                if (w_cfg_ok) begin
                    if (div_load) r_div <= div_val;
                    if (tgt_load) r_tgt <= tgt_val;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end

            case (r_state)
                StIdle: begin
                    if (start && !pause && !stop) begin
                        r_state <= StRun;
                        r_presc <= '0;
                        r_count <= '0;
                    end
                end
                StRun: begin
                    if (stop) begin
                        r_state <= StIdle;
                        r_presc <= '0;
                        r_count <= '0;
                    end else if (w_period_end) begin
                        // Tick and count complete even if pause arrives this cycle.
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                        r_count <= w_count_inc;
                        if (w_hit_tgt)  r_state <= StDone;
                        else if (pause) r_state <= StPause;
                    end else begin
                        r_presc <= r_presc + W'(1);
                        if (pause) r_state <= StPause;
                    end
                end
                StPause: begin
                    if (stop) begin
                        r_state <= StIdle;
                        r_presc <= '0;
                        r_count <= '0;
                    end else if (start && !pause) begin
                        r_state <= StRun;
                    end
                end
                StDone: begin
                    if (stop) begin
                        r_state <= StIdle;
                        r_presc <= '0;
                        r_count <= '0;
                    end else if (start && !pause) begin
                        r_state <= StRun;
                        r_presc <= '0;
                        r_count <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign tick       = r_tick;
    assign tick_count = r_count;
    assign cfg_err    = r_cfg_err;
    assign state      = r_state;
    assign busy       = (r_state == StRun) || (r_state == StPause);
    assign done       = (r_state == StDone);

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
- Run controller for the system-clock prescaler counter.
- Holds a programmable divide period and produces a one-cycle `tick` strobe every `div_reg+1` sysclk cycles.
- Counts ticks up to a programmable target and sequences IDLE/RUN/PAUSE/DONE from start/pause/stop commands.
- Replaces a fixed counter-MSB divider tap wherever a software-controlled, stoppable slow-rate strobe is needed (e.g. 1 Hz display update).

Parameters:
- W, 8, width of prescaler counter and divide value.
- CW, 8, width of tick counter and target.
- DIV_RST, 8'hFF, divide value loaded at reset (period = DIV_RST+1 cycles).

Ports:
- sysclk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled command: begin/resume run.
- pause  in  1  level-sampled command: freeze run.
- stop  in  1  level-sampled command: abort to IDLE.
- div_load  in  1  one-cycle strobe: capture div_val.
- div_val  in  W  new divide value; period = div_val+1 cycles.
- tgt_load  in  1  one-cycle strobe: capture tgt_val.
- tgt_val  in  CW  tick target; 0 = free-run.
- tick  out  1  one-cycle strobe at end of each prescaler period.
- tick_count  out  CW  ticks issued since start.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE (level).
- cfg_err  out  1  one-cycle pulse when a load strobe is rejected.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (reset=0, asynchronous), all registers forced immediately:
  - state=IDLE, prescaler=0, tick_count=0, tick=0, done=0, busy=0, cfg_err=0.
  - div_reg=DIV_RST, tgt_reg=0.
- Command priority when several commands are asserted in the same cycle: stop > pause > start.
- IDLE:
  - start=1 -> RUN next cycle; prescaler and tick_count cleared on that edge.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==div_reg: prescaler->0, tick=1 for exactly that next cycle, tick_count+1.
  - First tick appears div_reg+1 cycles after the RUN entry edge.
  - tgt_reg!=0 and the increment makes tick_count==tgt_reg -> DONE on the same edge; that final tick still pulses.
  - tgt_reg==0: tick_count wraps 2^CW-1 -> 0 silently; RUN never ends on its own.
  - pause=1 -> PAUSE; stop=1 -> IDLE, clearing prescaler and tick_count.
- PAUSE:
  - Prescaler and tick_count hold; no ticks.
  - start=1 (pause=0) -> RUN, resuming from held prescaler value with no clear.
  - stop=1 -> IDLE.
  - pause and start both high -> stay PAUSE.
- DONE:
  - done=1; counters hold final values.
  - start=1 -> RUN with counters cleared (restart).
  - stop=1 -> IDLE, counters cleared.
- Configuration loads:
  - div_load/tgt_load accepted only in IDLE or DONE; register updates on that edge.
  - In RUN/PAUSE the load is ignored and cfg_err pulses one cycle.
  - Both loads in the same accepted cycle: both captured.
- div_reg=0 -> tick every cycle while RUN (tick held high continuously).
- Same-cycle tick and pause: the tick/count update completes, then state enters PAUSE.
- Same-cycle tick and stop: stop wins; counters cleared, tick not asserted.
- Outputs are registered; busy/done/state are decoded from the registered state.

Test Plan:
- Reset mid-run: W=8, div 3, start, deassert reset after 6 cycles -> all outputs 0 asynchronously, div_reg=255 restored, state=IDLE.
- Period check: load div_val=3, tgt_val=0, start -> tick on cycles 4, 8, 12 after RUN entry; tick_count 1, 2, 3; tick width 1 cycle.
- Target stop: div_val=1, tgt_val=5, start -> 5 ticks at 2-cycle spacing, state=DONE and done=1 together with 5th tick, tick_count=5, no further ticks.
- Pause/resume: div_val=4, start, pause at prescaler=2 for 7 cycles, then start -> next tick exactly 3 cycles after resume, tick_count unchanged during pause.
- Command priority and rejection:
  - stop+pause+start together in RUN -> IDLE, counters cleared.
  - div_load in RUN -> cfg_err one pulse, period unchanged.
- Wrap and div 0: CW=8, tgt 0, div_val=0 -> tick continuous; tick_count 255 -> 0 after 256 cycles, state stays RUN.
